// File: rtl/regfile_sb.sv
// Multi-read register file (r0 hard-wired to zero) with a per-register issue scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned NREAD     = 3
) (
  input  logic                       clock,
  input  logic                       ctrl_reset,
  input  logic                       ctrl_writeEnable,
  input  logic [ADDR_BITS-1:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0]           data_writeReg,
  input  logic [NREAD*ADDR_BITS-1:0] ctrl_readReg,
  output logic [NREAD*WIDTH-1:0]     data_readReg,
  output logic [NREAD-1:0]           busy_readReg,
  input  logic                       ctrl_issueEnable,
  input  logic [ADDR_BITS-1:0]       ctrl_issueReg,
  output logic                       issue_ready,
  output logic [ADDR_BITS-1:0]       busy_count
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  // Entry 0 and busy bit 0 are reset and never written, so they always read as zero.
  logic [WIDTH-1:0]     regs_q [DEPTH];
  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [ADDR_BITS-1:0] count_q, count_d;
  logic                 wr_en, issue_set, cnt_inc, cnt_dec;

  assign wr_en       = ctrl_writeEnable && (ctrl_writeReg != '0);
  assign issue_ready = !busy_q[ctrl_issueReg] ||
                       (ctrl_writeEnable && (ctrl_writeReg == ctrl_issueReg));
  assign issue_set   = ctrl_issueEnable && issue_ready && (ctrl_issueReg != '0);
  assign busy_count  = count_q;

  // Set is applied after clear so a new producer wins over the retiring one.
  always_comb begin
    busy_d  = busy_q;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    if (wr_en) busy_d[ctrl_writeReg] = 1'b0;
    if (issue_set) busy_d[ctrl_issueReg] = 1'b1;
    cnt_inc = issue_set && !busy_q[ctrl_issueReg];
    cnt_dec = wr_en && busy_q[ctrl_writeReg] &&
              !(issue_set && (ctrl_issueReg == ctrl_writeReg));
    count_d = count_q + ADDR_BITS'(cnt_inc) - ADDR_BITS'(cnt_dec);
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) regs_q[ctrl_writeReg] <= data_writeReg;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  for (genvar k = 0; k < int'(NREAD); k++) begin : g_read
    logic [ADDR_BITS-1:0] addr;
    assign addr = ctrl_readReg[k*ADDR_BITS +: ADDR_BITS];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so held-reset reads stay zero.
    logic hit;
    assign hit = ctrl_reset && wr_en && (addr == ctrl_writeReg);
    assign data_readReg[k*WIDTH +: WIDTH] = hit ? data_writeReg : regs_q[addr];
    assign busy_readReg[k]                = busy_q[addr] && !hit;
`else
    assign data_readReg[k*WIDTH +: WIDTH] = regs_q[addr];
    assign busy_readReg[k]                = busy_q[addr];
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expectations are queued at stimulus time and
// compared in order against samples taken away from the rising edge.
module tb_regfile_sb;
  localparam int W = 32;
  localparam int A = 5;
  localparam int N = 3;

  logic           clock = 1'b0;
  logic           ctrl_reset;
  logic           ctrl_writeEnable;
  logic [A-1:0]   ctrl_writeReg;
  logic [W-1:0]   data_writeReg;
  logic [N*A-1:0] ctrl_readReg;
  logic [N*W-1:0] data_readReg;
  logic [N-1:0]   busy_readReg;
  logic           ctrl_issueEnable;
  logic [A-1:0]   ctrl_issueReg;
  logic           issue_ready;
  logic [A-1:0]   busy_count;

  regfile_sb #(.WIDTH(W), .ADDR_BITS(A), .NREAD(N)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readReg     (ctrl_readReg),
    .data_readReg     (data_readReg),
    .busy_readReg     (busy_readReg),
    .ctrl_issueEnable (ctrl_issueEnable),
    .ctrl_issueReg    (ctrl_issueReg),
    .issue_ready      (issue_ready),
    .busy_count       (busy_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] obs[$];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [31:0] rd(input int k);
    return data_readReg[k*W +: W];
  endfunction

  task automatic set_rd(input logic [A-1:0] a0, input logic [A-1:0] a1, input logic [A-1:0] a2);
    ctrl_readReg = {a2, a1, a0};
  endtask

  task automatic expect_v(input string name, input logic [31:0] v);
    sb.push_back('{name, v});
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] o;
    ctrl_reset = 1'b0;
    @(negedge clock);
    set_rd(5'd0, 5'd7, 5'd31);
    expect_v("rst_d0", 0); expect_v("rst_d1", 0); expect_v("rst_d2", 0);
    expect_v("rst_busy", 0); expect_v("rst_ready", 1); expect_v("rst_count", 0);
    #1;
    obs.push_back(rd(0)); obs.push_back(rd(1)); obs.push_back(rd(2));
    obs.push_back(32'(busy_readReg)); obs.push_back(32'(issue_ready));
    obs.push_back(32'(busy_count));
    @(negedge clock);
    ctrl_reset = 1'b1;
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_write();
    exp_t e;
    logic [31:0] o;
    @(negedge clock);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
    @(negedge clock);
    ctrl_writeReg = 5'd0; data_writeReg = 32'h12345678;
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    set_rd(5'd5, 5'd0, 5'd5);
    expect_v("wr_r5_p0", 32'hDEADBEEF); expect_v("wr_r0_p1", 0); expect_v("wr_r5_p2", 32'hDEADBEEF);
    #1;
    obs.push_back(rd(0)); obs.push_back(rd(1)); obs.push_back(rd(2));
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    logic [31:0] o;
    @(negedge clock);
    ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd9;
    set_rd(5'd9, 5'd0, 5'd0);
    expect_v("iss1_ready", 1);
    #1 obs.push_back(32'(issue_ready));
    @(negedge clock);
    expect_v("iss2_ready", 0); expect_v("iss2_count", 1); expect_v("iss2_busy", 3'b001);
    #1;
    obs.push_back(32'(issue_ready)); obs.push_back(32'(busy_count));
    obs.push_back(32'(busy_readReg));
    @(negedge clock);
    ctrl_issueEnable = 1'b0;
    expect_v("refused_count", 1);
    #1 obs.push_back(32'(busy_count));
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h000000A5;
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    expect_v("clr_count", 0); expect_v("clr_data", 32'hA5); expect_v("clr_busy", 0);
    #1;
    obs.push_back(32'(busy_count)); obs.push_back(rd(0)); obs.push_back(32'(busy_readReg));
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    logic [31:0] o;
    @(negedge clock);
    ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd3;
    @(negedge clock);
    ctrl_issueReg = 5'd6;
    @(negedge clock);
    // r3 busy: write it and re-issue it in the same cycle
    ctrl_issueReg = 5'd3;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h1;
    expect_v("same_pre_count", 2); expect_v("same_ready", 1);
    #1 begin obs.push_back(32'(busy_count)); obs.push_back(32'(issue_ready)); end
    @(negedge clock);
    ctrl_issueEnable = 1'b0; ctrl_writeEnable = 1'b0;
    set_rd(5'd3, 5'd0, 5'd0);
    expect_v("same_data", 1); expect_v("same_busy", 3'b001); expect_v("same_count", 2);
    #1;
    obs.push_back(rd(0)); obs.push_back(32'(busy_readReg)); obs.push_back(32'(busy_count));
    ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd4;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd6; data_writeReg = 32'h66;
    @(negedge clock);
    ctrl_issueEnable = 1'b0; ctrl_writeEnable = 1'b0;
    set_rd(5'd4, 5'd6, 5'd3);
    expect_v("mix_count", 2); expect_v("mix_busy", 3'b101); expect_v("mix_r6", 32'h66);
    #1;
    obs.push_back(32'(busy_count)); obs.push_back(32'(busy_readReg)); obs.push_back(rd(1));
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [31:0] o;
    @(negedge clock);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd12; data_writeReg = 32'h1111;
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd12;
    @(negedge clock);
    ctrl_issueEnable = 1'b0;
    set_rd(5'd0, 5'd0, 5'd12);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd12; data_writeReg = 32'hCAFE;
`ifdef REGFILE_BYPASS_EN
    expect_v("byp_data", 32'hCAFE); expect_v("byp_busy", 3'b000);
`else
    expect_v("byp_data", 32'h1111); expect_v("byp_busy", 3'b100);
`endif
    expect_v("byp_count", 3);
    #1;
    obs.push_back(rd(2)); obs.push_back(32'(busy_readReg)); obs.push_back(32'(busy_count));
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    expect_v("byp_next_data", 32'hCAFE); expect_v("byp_next_busy", 0); expect_v("byp_next_count", 2);
    #1;
    obs.push_back(rd(2)); obs.push_back(32'(busy_readReg)); obs.push_back(32'(busy_count));
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] o;
    @(negedge clock);
    ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd20;
    @(negedge clock);
    ctrl_issueReg = 5'd21;
    @(negedge clock);
    ctrl_issueEnable = 1'b0;
    set_rd(5'd3, 5'd4, 5'd7);
    expect_v("mid_pre_count", 4);
    #1 obs.push_back(32'(busy_count));
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'hBEEF;
    #1 ctrl_reset = 1'b0;
    expect_v("mid_count", 0); expect_v("mid_d0", 0); expect_v("mid_d2", 0);
    expect_v("mid_busy", 0); expect_v("mid_ready", 1);
    #1;
    obs.push_back(32'(busy_count)); obs.push_back(rd(0)); obs.push_back(rd(2));
    obs.push_back(32'(busy_readReg)); obs.push_back(32'(issue_ready));
    @(negedge clock);
    ctrl_reset = 1'b1; ctrl_writeEnable = 1'b0;
    @(negedge clock);
    expect_v("mid_lost_wr", 0); expect_v("mid_post_count", 0);
    #1;
    obs.push_back(rd(2)); obs.push_back(32'(busy_count));
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      end
    end
  endtask

  initial begin
    ctrl_reset       = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_readReg     = '0;
    ctrl_issueEnable = 1'b0;
    ctrl_issueReg    = '0;
    test_reset();
    test_write();
    test_scoreboard();
    test_same_cycle();
    test_bypass();
    test_reset_mid();
    if (sb.size() != 0 || obs.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", sb.size(), obs.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read register file with an integrated issue scoreboard, the next-generation general-purpose register block for the processor datapath. It provides NREAD combinational read ports and one write port, with register 0 hard-wired to zero. Per-register busy bits track in-flight multicycle producers so decode can detect RAW/WAW hazards. An optional write-to-read bypass lets the writeback stage forward to decode in the same cycle.

## Interface
- WIDTH, 32: data width of each register.
- ADDR_BITS, 5: register index width; depth = 2^ADDR_BITS.
- NREAD, 3: number of read ports (≥1).

- clock  in  1  single clock; all state updates on rising edge.
- ctrl_reset  in  1  reset, asynchronous and active-low; low clears all state immediately.
- ctrl_writeEnable  in  1  write strobe for the writeback port.
- ctrl_writeReg  in  ADDR_BITS  write index.
- data_writeReg  in  WIDTH  write data.
- ctrl_readReg  in  NREAD*ADDR_BITS  read indices; port k uses bits [k*ADDR_BITS +: ADDR_BITS].
- data_readReg  out  NREAD*WIDTH  read data; port k on bits [k*WIDTH +: WIDTH].
- busy_readReg  out  NREAD  busy bit of the register addressed by each read port.
- ctrl_issueEnable  in  1  request to mark a destination register busy.
- ctrl_issueReg  in  ADDR_BITS  destination index of the issuing instruction.
- issue_ready  out  1  high when an issue this cycle will be accepted.
- busy_count  out  ADDR_BITS  number of registers currently busy.

## Operation
- Storage: 2^ADDR_BITS registers of WIDTH bits; register 0 is not stored and always reads 0.
- Write: on rising edge with ctrl_writeEnable=1 and ctrl_writeReg≠0, register takes data_writeReg; writes to index 0 are discarded.
- Read: each port independently and combinationally returns its addressed register; all ports may address the same register.
- Scoreboard: one busy bit per register; bit 0 is constantly 0.
- Clear: a write with ctrl_writeEnable=1 to index r clears busy[r] at that edge.
- Set: ctrl_issueEnable=1 and issue_ready=1 sets busy[ctrl_issueReg] at the edge; issue to index 0 is accepted and has no effect.
- issue_ready = !busy[ctrl_issueReg] OR (ctrl_writeEnable AND ctrl_writeReg==ctrl_issueReg), which prevents a second in-flight producer (WAW) to the same register.
- A refused issue (issue_ready=0) changes no state; the requester holds the request and retries.
- Simultaneous write and accepted issue to the same register r: the data write occurs and busy[r] ends at 1 (the new producer wins).
- busy_readReg[k] = busy[ctrl_readReg[k]], or 0 when the bypass clears it (see Configuration).
- busy_count: registered counter; it is incremented on a set of a previously clear bit and decremented on a clear of a set bit. A set and a clear of different bits in the same cycle leave it unchanged. The case of set and clear on the same register is covered above (the bit stays 1, so the count is unchanged).

## Timing
- Reset (ctrl_reset low, asynchronous): all registers 0, all busy bits 0, busy_count 0. While reset is held, data_readReg is all zeros, busy_readReg 0, issue_ready 1.
- Write latency: 1 edge; the new value is visible on read ports the cycle after the write edge (without bypass).
- Busy set/clear: takes effect at the edge; visible on busy_readReg/busy_count the following cycle.
- Read ports, busy_readReg, issue_ready: purely combinational from current state and inputs.
- Reset asserted mid-operation discards any pending write or issue in that cycle. Deassertion is synchronised externally; the first edge after release performs normal operation.

## Configuration
- REGFILE_BYPASS_EN defined: any read port whose index equals ctrl_writeReg (≠0) while ctrl_writeEnable=1 returns data_writeReg in that same cycle, and its busy_readReg is forced to 0.
- REGFILE_BYPASS_EN undefined: no forwarding. Read ports return the stored value, and busy_readReg reflects the stored busy bit until the edge.

## Test plan
- Reset then read all ports at indices 0, 7, 31 -> all data 0, busy_readReg 0, issue_ready 1, busy_count 0.
- Write 0xDEADBEEF to r5, then 0x12345678 to r0; read r5/r0/r5 on 3 ports -> 0xDEADBEEF, 0, 0xDEADBEEF.
- Issue r9 -> next cycle busy_count 1; second issue r9 -> issue_ready 0, count stays 1; write r9 with 0xA5 -> busy cleared, count 0, read 0xA5.
- Same cycle: write r3 (busy) with 0x1 and issue r3 -> issue_ready 1; r3 reads 0x1 and stays busy, count unchanged; same cycle issue r4, clear r6 -> count unchanged.
- Bypass: write r12=0xCAFE while a port reads r12 -> with REGFILE_BYPASS_EN, 0xCAFE and busy 0 in the same cycle; without it, the old value that cycle and 0xCAFE the next.
- Assert ctrl_reset low mid-cycle with 4 busy registers -> immediately busy_count 0 and all reads 0, and the pending write is lost.
